param_data_loader: RTL and testbench

PARAM_DATA_LOADER -- requirements
Module: param_data_loader

---
 rtl/loader_pkg.sv | 17 +
 rtl/param_data_loader_if.sv | 32 +++
 rtl/loader_addr_gen.sv | 86 ++++++++
 rtl/param_data_loader.sv | 123 ++++++++++++
 tb/tb_param_data_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared state encoding and default parameter values for the parameter/data loader.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdW,
    StRdF,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAddrW = 6;
  localparam int unsigned DefK     = 3;
  localparam int unsigned DefImgW  = 4;

endpackage

// File: rtl/param_data_loader_if.sv
// Loader bus: window request from the controller, memory read port and PE-facing pair.
interface param_data_loader_if
  import loader_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
);

  logic              start;
  logic [ADDR_W-1:0] weight_baseaddr;
  logic [ADDR_W-1:0] feature_baseaddr;
  logic [DATA_W-1:0] q;
  logic [ADDR_W-1:0] addr;
  logic              re;
  logic [DATA_W-1:0] w_out;
  logic [DATA_W-1:0] f_out;
  logic              acc_en;
  logic              rst_pe;
  logic              busy;
  logic              is_done_o;

  modport master (
    output start, weight_baseaddr, feature_baseaddr, q,
    input  addr, re, w_out, f_out, acc_en, rst_pe, busy, is_done_o
  );

  modport slave (
    input  start, weight_baseaddr, feature_baseaddr, q,
    output addr, re, w_out, f_out, acc_en, rst_pe, busy, is_done_o
  );

endinterface

// File: rtl/loader_addr_gen.sv
// Window address generator: latches the bases, walks the K x K window in raster order and
// supplies the next registered read address (weight or feature).
module loader_addr_gen
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned K      = DefK,
  parameter int unsigned IMG_W  = DefImgW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              feat_sel_i,
  input  logic [ADDR_W-1:0] wbase_i,
  input  logic [ADDR_W-1:0] fbase_i,
  output logic [ADDR_W-1:0] nxt_addr_o,
  output logic              last_o
);

  localparam int unsigned N    = K * K;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) + 1 : 1;

  logic [ADDR_W-1:0] wbase_q, wbase_d;
  logic [ADDR_W-1:0] fbase_q, fbase_d;
  logic [ADDR_W-1:0] row_off_q, row_off_d;
  logic [CntW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   col_q, col_d;
  logic [ADDR_W-1:0] w_addr_next;
  logic [ADDR_W-1:0] f_addr;

  always_comb begin
    wbase_d   = wbase_q;
    fbase_d   = fbase_q;
    row_off_d = row_off_q;
    idx_d     = idx_q;
    col_d     = col_q;
    if (load_i) begin
      wbase_d   = wbase_i;
      fbase_d   = fbase_i;
      row_off_d = '0;
      idx_d     = '0;
      col_d     = '0;
    end else if (step_i) begin
      idx_d = idx_q + CntW'(1);
      // End of a kernel row: jump the feature pointer down one image row.
      if (col_q == CntW'(K - 1)) begin
        col_d     = '0;
        row_off_d = row_off_q + ADDR_W'(IMG_W);
      end else begin
        col_d = col_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbase_q   <= '0;
      fbase_q   <= '0;
      row_off_q <= '0;
      idx_q     <= '0;
      col_q     <= '0;
    end else begin
      wbase_q   <= wbase_d;
      fbase_q   <= fbase_d;
      row_off_q <= row_off_d;
      idx_q     <= idx_d;
      col_q     <= col_d;
    end
  end

  assign w_addr_next = wbase_q + ADDR_W'(idx_q) + ADDR_W'(1);
  assign f_addr      = fbase_q + row_off_q + ADDR_W'(col_q);
  assign last_o      = (idx_q == CntW'(N - 1));

  always_comb begin
    if (load_i) begin
      nxt_addr_o = wbase_i;
    end else if (feat_sel_i) begin
      nxt_addr_o = f_addr;
    end else begin
      nxt_addr_o = w_addr_next;
    end
  end

endmodule

// File: rtl/param_data_loader.sv
// Loads one K x K weight/feature window from a synchronous-read memory and presents
// weight/feature pairs to a PE, alternating weight and feature reads.
module param_data_loader
  import loader_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned K      = DefK,
  parameter int unsigned IMG_W  = DefImgW
) (
  input logic               clk,
  input logic               rst,
  param_data_loader_if.slave bus
);

  if (IMG_W < K) begin : g_bad_img_w
    $error("param_data_loader: IMG_W must be >= K");
  end

  state_e            state_q, state_d;
  logic              drain_q, drain_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              re_q, re_d;
  logic [DATA_W-1:0] w_hold_q, w_hold_d;
  logic [DATA_W-1:0] w_out_q, w_out_d;
  logic [DATA_W-1:0] f_out_q, f_out_d;
  logic              acc_en_q, acc_en_d;
  logic              f_pend_q, f_pend_d;
  logic              rst_pe_q, rst_pe_d;

  logic              accept;
  logic              step;
  logic              feat_sel;
  logic              last_elem;
  logic [ADDR_W-1:0] nxt_addr;

  assign accept   = bus.start && ((state_q == StIdle) || (state_q == StDone));
  assign step     = (state_q == StRdF);
  assign feat_sel = (state_q == StRdW);

  loader_addr_gen #(
    .ADDR_W(ADDR_W),
    .K     (K),
    .IMG_W (IMG_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .step_i    (step),
    .feat_sel_i(feat_sel),
    .wbase_i   (bus.weight_baseaddr),
    .fbase_i   (bus.feature_baseaddr),
    .nxt_addr_o(nxt_addr),
    .last_o    (last_elem)
  );

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRdW;
      StRdW:   state_d = StRdF;
      StRdF: begin
        state_d = last_elem ? StDrain : StRdW;
        drain_d = 1'b0;
      end
      // Two drain cycles let the last feature word come back and be registered.
      StDrain: begin
        drain_d = ~drain_q;
        if (drain_q) state_d = StDone;
      end
      StDone:  state_d = accept ? StRdW : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    re_d     = (state_d == StRdW) || (state_d == StRdF);
    addr_d   = re_d ? nxt_addr : '0;
    w_hold_d = (state_q == StRdF) ? bus.q : w_hold_q;
    f_pend_d = (state_q == StRdF);
    acc_en_d = f_pend_q;
    w_out_d  = f_pend_q ? w_hold_q : w_out_q;
    f_out_d  = f_pend_q ? bus.q : f_out_q;
    rst_pe_d = accept;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      drain_q  <= 1'b0;
      addr_q   <= '0;
      re_q     <= 1'b0;
      w_hold_q <= '0;
      w_out_q  <= '0;
      f_out_q  <= '0;
      acc_en_q <= 1'b0;
      f_pend_q <= 1'b0;
      rst_pe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      addr_q   <= addr_d;
      re_q     <= re_d;
      w_hold_q <= w_hold_d;
      w_out_q  <= w_out_d;
      f_out_q  <= f_out_d;
      acc_en_q <= acc_en_d;
      f_pend_q <= f_pend_d;
      rst_pe_q <= rst_pe_d;
    end
  end

  assign bus.addr      = addr_q;
  assign bus.re        = re_q;
  assign bus.w_out     = w_out_q;
  assign bus.f_out     = f_out_q;
  assign bus.acc_en    = acc_en_q;
  assign bus.rst_pe    = rst_pe_q | ~rst;
  assign bus.busy      = (state_q == StRdW) || (state_q == StRdF) || (state_q == StDrain);
  assign bus.is_done_o = (state_q == StDone);

endmodule

// File: tb/tb_param_data_loader.sv
// Bench for param_data_loader: directed vector table plus randomized windows checked
// cycle by cycle against a formula-based model of the window timing.
module tb_param_data_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_data_loader_if #(.DATA_W(8), .ADDR_W(6)) bus1 ();
  param_data_loader_if #(.DATA_W(8), .ADDR_W(6)) bus2 ();

  param_data_loader #(.DATA_W(8), .ADDR_W(6), .K(3), .IMG_W(4)) u_dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1.slave)
  );

  param_data_loader #(.DATA_W(8), .ADDR_W(6), .K(2), .IMG_W(5)) u_dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2.slave)
  );

  logic [7:0] mem [64];

  always @(posedge clk) begin
    if (bus1.re) bus1.q <= mem[bus1.addr];
    if (bus2.re) bus2.q <= mem[bus2.addr];
  end

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_w [2];
  logic [7:0] exp_f [2];
  logic [5:0] obs_fa [16];
  int nobs;

  typedef struct {
    logic [5:0] wb;
    logic [5:0] fb;
    logic [5:0] fa [9];
  } vec_t;
  vec_t vecs [3];

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, n, act, exp);
    end
  endtask

  task automatic drive_start(input bit sel, input bit v, input logic [5:0] wb, input logic [5:0] fb);
    if (sel) begin
      bus2.start = v; bus2.weight_baseaddr = wb; bus2.feature_baseaddr = fb;
    end else begin
      bus1.start = v; bus1.weight_baseaddr = wb; bus1.feature_baseaddr = fb;
    end
  endtask

  task automatic sample(input bit sel, output logic [5:0] a, output logic re, output logic acc,
                        output logic busy, output logic done, output logic rpe,
                        output logic [7:0] w, output logic [7:0] f);
    if (sel) begin
      a = bus2.addr; re = bus2.re; acc = bus2.acc_en; busy = bus2.busy;
      done = bus2.is_done_o; rpe = bus2.rst_pe; w = bus2.w_out; f = bus2.f_out;
    end else begin
      a = bus1.addr; re = bus1.re; acc = bus1.acc_en; busy = bus1.busy;
      done = bus1.is_done_o; rpe = bus1.rst_pe; w = bus1.w_out; f = bus1.f_out;
    end
  endtask

  function automatic int feat_addr(input int fb, input int i, input int k, input int imgw);
    return (fb + (i / k) * imgw + (i % k)) % 64;
  endfunction

  task automatic check_quiet(input bit sel, input string nm, input bit in_reset);
    logic [5:0] a; logic re, acc, busy, done, rpe; logic [7:0] w, f;
    sample(sel, a, re, acc, busy, done, rpe, w, f);
    chk({nm, "_addr"}, 0, a, 0);
    chk({nm, "_re"}, 0, re, 0);
    chk({nm, "_acc"}, 0, acc, 0);
    chk({nm, "_busy"}, 0, busy, 0);
    chk({nm, "_done"}, 0, done, 0);
    chk({nm, "_rst_pe"}, 0, rpe, in_reset);
    chk({nm, "_w_out"}, 0, w, exp_w[sel]);
    chk({nm, "_f_out"}, 0, f, exp_f[sel]);
  endtask

  // Start must already be driven for the accepting edge; checks cycles 1..2N+3.
  task automatic run_window(input bit sel, input int k, input int imgw,
                            input logic [5:0] wb, input logic [5:0] fb,
                            input int poke_at, input int abort_at,
                            input bit chain, input logic [5:0] nwb, input logic [5:0] nfb);
    int nn;
    int last;
    int i;
    logic [5:0] a; logic re, acc, busy, done, rpe; logic [7:0] w, f;
    logic [5:0] ea;
    bit ere, eacc;
    nn   = k * k;
    last = 2 * nn + 3;
    nobs = 0;
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      drive_start(sel, 1'b0, wb, fb);
      ere = (n <= 2 * nn);
      ea  = '0;
      if (ere) begin
        if (n % 2 == 1) ea = 6'((int'(wb) + (n - 1) / 2) % 64);
        else            ea = 6'(feat_addr(int'(fb), (n - 2) / 2, k, imgw));
      end
      eacc = (n % 2 == 0) && (n >= 4) && (n <= 2 * nn + 2);
      if (eacc) begin
        i = (n - 4) / 2;
        exp_w[sel] = mem[(int'(wb) + i) % 64];
        exp_f[sel] = mem[feat_addr(int'(fb), i, k, imgw)];
      end
      sample(sel, a, re, acc, busy, done, rpe, w, f);
      chk("addr", n, a, ea);
      chk("re", n, re, ere);
      chk("acc_en", n, acc, eacc);
      chk("busy", n, busy, n <= 2 * nn + 2);
      chk("is_done", n, done, n == last);
      chk("rst_pe", n, rpe, n == 1);
      chk("w_out", n, w, exp_w[sel]);
      chk("f_out", n, f, exp_f[sel]);
      if (ere && (n % 2 == 0)) begin
        obs_fa[nobs] = a;
        nobs++;
      end
      if (n == poke_at) drive_start(sel, 1'b1, ~wb, ~fb);
      if (n == abort_at) begin
        rst = 1'b0;
        #1;
        exp_w[0] = '0; exp_f[0] = '0; exp_w[1] = '0; exp_f[1] = '0;
        check_quiet(sel, "abort", 1'b1);
        return;
      end
      if (chain && n == last) drive_start(sel, 1'b1, nwb, nfb);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=0 got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] cur_wb, cur_fb, nxt_wb, nxt_fb;
    int poke;
    bit chain;

    vecs[0].wb = 6'h00; vecs[0].fb = 6'h10;
    vecs[0].fa = '{6'h10, 6'h11, 6'h12, 6'h14, 6'h15, 6'h16, 6'h18, 6'h19, 6'h1A};
    vecs[1].wb = 6'h20; vecs[1].fb = 6'h3E;
    vecs[1].fa = '{6'h3E, 6'h3F, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
    vecs[2].wb = 6'h3F; vecs[2].fb = 6'h05;
    vecs[2].fa = '{6'h05, 6'h06, 6'h07, 6'h09, 6'h0A, 6'h0B, 6'h0D, 6'h0E, 6'h0F};

    for (int j = 0; j < 64; j++) mem[j] = 8'($urandom);
    exp_w[0] = '0; exp_f[0] = '0; exp_w[1] = '0; exp_f[1] = '0;
    drive_start(0, 1'b0, '0, '0);
    drive_start(1, 1'b0, '0, '0);

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet(0, "reset", 1'b1);
    check_quiet(1, "reset2", 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_quiet(0, "idle", 1'b0);

    // Directed vector table
    for (int v = 0; v < 3; v++) begin
      drive_start(0, 1'b1, vecs[v].wb, vecs[v].fb);
      run_window(0, 3, 4, vecs[v].wb, vecs[v].fb, -1, -1, 1'b0, '0, '0);
      for (int j = 0; j < 9; j++) chk("fa_table", j, obs_fa[j], vecs[v].fa[j]);
      @(negedge clk);
      check_quiet(0, "post_idle", 1'b0);
    end

    // Start pulsed in cycle 5 is ignored
    drive_start(0, 1'b1, 6'h00, 6'h10);
    run_window(0, 3, 4, 6'h00, 6'h10, 5, -1, 1'b0, '0, '0);
    @(negedge clk);
    check_quiet(0, "poke_idle", 1'b0);

    // Back-to-back: start in DONE chains straight into a second identical window
    drive_start(0, 1'b1, 6'h00, 6'h10);
    run_window(0, 3, 4, 6'h00, 6'h10, -1, -1, 1'b1, 6'h00, 6'h10);
    run_window(0, 3, 4, 6'h00, 6'h10, -1, -1, 1'b0, '0, '0);
    @(negedge clk);
    check_quiet(0, "b2b_idle", 1'b0);

    // Reset in cycle 7 abandons the window
    drive_start(0, 1'b1, 6'h04, 6'h21);
    run_window(0, 3, 4, 6'h04, 6'h21, -1, 7, 1'b0, '0, '0);
    repeat (3) begin
      @(negedge clk);
      check_quiet(0, "in_reset", 1'b1);
    end
    rst = 1'b1;
    @(negedge clk);
    check_quiet(0, "after_reset", 1'b0);
    drive_start(0, 1'b1, 6'h04, 6'h21);
    run_window(0, 3, 4, 6'h04, 6'h21, -1, -1, 1'b0, '0, '0);
    chk("post_reset_pairs", 0, nobs, 9);
    @(negedge clk);
    check_quiet(0, "clean_idle", 1'b0);

    // Randomized windows, some chained, some with ignored start pulses
    cur_wb = 6'($urandom_range(0, 63));
    cur_fb = 6'($urandom_range(0, 63));
    drive_start(0, 1'b1, cur_wb, cur_fb);
    for (int r = 0; r < 10; r++) begin
      poke   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 20)) : -1;
      chain  = (r < 9) && ($urandom_range(0, 2) != 0);
      nxt_wb = 6'($urandom_range(0, 63));
      nxt_fb = 6'($urandom_range(0, 63));
      run_window(0, 3, 4, cur_wb, cur_fb, poke, -1, chain, nxt_wb, nxt_fb);
      if (!chain) begin
        @(negedge clk);
        check_quiet(0, "rand_idle", 1'b0);
        drive_start(0, 1'b1, nxt_wb, nxt_fb);
      end
      cur_wb = nxt_wb;
      cur_fb = nxt_fb;
    end
    @(negedge clk);
    drive_start(0, 1'b0, '0, '0);

    // K=2, IMG_W=5 instance
    drive_start(1, 1'b1, 6'h30, 6'h00);
    run_window(1, 2, 5, 6'h30, 6'h00, -1, -1, 1'b0, '0, '0);
    chk("k2_fa0", 0, obs_fa[0], 6'h00);
    chk("k2_fa1", 1, obs_fa[1], 6'h01);
    chk("k2_fa2", 2, obs_fa[2], 6'h05);
    chk("k2_fa3", 3, obs_fa[3], 6'h06);
    @(negedge clk);
    check_quiet(1, "k2_idle", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
